// File: rtl/debug_cmd_decoder.sv
// Byte-level command decoder for the debug UART link: turns opcode bytes into
// debug-controller pulses, a ping reply request and an instruction-memory write port.
module debug_cmd_decoder #(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              cmd_pause,
  output logic              cmd_resume,
  output logic [31:0]       bp_addr,
  output logic              cmd_next,
  output logic              ok_req,
  input  logic              ok_ack,
  output logic              prog_active,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_data,
  output logic              prog_done,
  output logic              frame_error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]   TO_LIMIT    = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX    = {ADDR_W{1'b1}};
  localparam logic [7:0]        OP_PING     = 8'h03;
  localparam logic [7:0]        OP_PAUSE    = 8'h04;
  localparam logic [7:0]        OP_RESUME   = 8'h05;
  localparam logic [7:0]        OP_NEXT     = 8'h06;
  localparam logic [7:0]        OP_PROGRAM  = 8'h07;
  localparam logic [7:0]        OP_NONE     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESUME_ARG = 2'd1,
    PROG_WORD  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        byte_cnt_r, byte_cnt_s;
  logic [23:0]       shadow_r, shadow_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
  logic              full_r, full_s;
  logic              timeout_s;
  logic              ping_s;
  logic [31:0]       word_s;
  logic              cmd_pause_s, cmd_resume_s, cmd_next_s, ok_req_s, prog_active_s;
  logic              prog_we_s, prog_done_s, frame_error_s;
  logic [31:0]       bp_addr_s, prog_data_s;
  logic [ADDR_W-1:0] prog_addr_s;

  // Next-state, datapath and pulse decode for the byte stream
  always_comb begin
    state_s       = state_r;
    byte_cnt_s    = byte_cnt_r;
    shadow_s      = shadow_r;
    full_s        = full_r;
    cmd_pause_s   = 1'b0;
    cmd_resume_s  = 1'b0;
    cmd_next_s    = 1'b0;
    prog_we_s     = 1'b0;
    prog_done_s   = 1'b0;
    frame_error_s = 1'b0;
    ping_s        = 1'b0;
    bp_addr_s     = bp_addr;
    prog_data_s   = prog_data;
    prog_active_s = prog_active;
    // Little-endian: the first three bytes sit in the shadow, the fourth is on rx_data
    word_s        = {rx_data, shadow_r};
    timeout_s     = (state_r != IDLE) && !rx_valid && (to_cnt_r == TO_LAST);

    // The address steps one cycle after each write and saturates at the top word
    if (prog_we && (prog_addr != ADDR_MAX)) begin
      prog_addr_s = prog_addr + ADDR_W'(1);
    end else begin
      prog_addr_s = prog_addr;
    end

    if (rx_valid) begin
      to_cnt_s = {TO_W{1'b0}};
    end else if ((state_r != IDLE) && (to_cnt_r != TO_LIMIT)) begin
      to_cnt_s = to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_s = to_cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_PING:    ping_s      = 1'b1;
            OP_PAUSE:   cmd_pause_s = 1'b1;
            OP_NEXT:    cmd_next_s  = 1'b1;
            OP_RESUME: begin
              state_s    = RESUME_ARG;
              byte_cnt_s = 2'd0;
            end
            OP_PROGRAM: begin
              state_s       = PROG_WORD;
              byte_cnt_s    = 2'd0;
              prog_addr_s   = {ADDR_W{1'b0}};
              prog_active_s = 1'b1;
              full_s        = 1'b0;
            end
            OP_NONE:    ping_s        = 1'b0;
            default:    frame_error_s = 1'b1;
          endcase
        end else begin
          state_s = IDLE;
        end
      end

      RESUME_ARG: begin
        if (rx_valid) begin
          if (byte_cnt_r == 2'd3) begin
            bp_addr_s    = word_s;
            cmd_resume_s = 1'b1;
            state_s      = IDLE;
            byte_cnt_s   = 2'd0;
          end else begin
            shadow_s   = {rx_data, shadow_r[23:8]};
            byte_cnt_s = byte_cnt_r + 2'd1;
          end
        end else if (timeout_s) begin
          frame_error_s = 1'b1;
          state_s       = IDLE;
          byte_cnt_s    = 2'd0;
          to_cnt_s      = {TO_W{1'b0}};
        end else begin
          state_s = RESUME_ARG;
        end
      end

      PROG_WORD: begin
        if (rx_valid) begin
          if (byte_cnt_r == 2'd3) begin
            byte_cnt_s = 2'd0;
            if (full_r) begin
              frame_error_s = 1'b1;
            end else begin
              prog_we_s   = 1'b1;
              prog_data_s = word_s;
              full_s      = (prog_addr == ADDR_MAX);
            end
          end else begin
            shadow_s   = {rx_data, shadow_r[23:8]};
            byte_cnt_s = byte_cnt_r + 2'd1;
          end
        end else if (timeout_s) begin
          prog_active_s = 1'b0;
          state_s       = IDLE;
          byte_cnt_s    = 2'd0;
          to_cnt_s      = {TO_W{1'b0}};
          if (byte_cnt_r == 2'd0) begin
            prog_done_s = 1'b1;
          end else begin
            frame_error_s = 1'b1;
          end
        end else begin
          state_s = PROG_WORD;
        end
      end

      default: begin
        state_s    = IDLE;
        byte_cnt_s = 2'd0;
        to_cnt_s   = {TO_W{1'b0}};
      end
    endcase

    // A ping wins over a same-cycle ack so the pending reply is never lost
    if (ping_s) begin
      ok_req_s = 1'b1;
    end else if (ok_ack) begin
      ok_req_s = 1'b0;
    end else begin
      ok_req_s = ok_req;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      byte_cnt_r  <= 2'd0;
      shadow_r    <= 24'd0;
      to_cnt_r    <= {TO_W{1'b0}};
      full_r      <= 1'b0;
      cmd_pause   <= 1'b0;
      cmd_resume  <= 1'b0;
      cmd_next    <= 1'b0;
      ok_req      <= 1'b0;
      prog_active <= 1'b0;
      prog_we     <= 1'b0;
      prog_done   <= 1'b0;
      frame_error <= 1'b0;
      bp_addr     <= 32'd0;
      prog_addr   <= {ADDR_W{1'b0}};
      prog_data   <= 32'd0;
    end else begin
      state_r     <= state_s;
      byte_cnt_r  <= byte_cnt_s;
      shadow_r    <= shadow_s;
      to_cnt_r    <= to_cnt_s;
      full_r      <= full_s;
      cmd_pause   <= cmd_pause_s;
      cmd_resume  <= cmd_resume_s;
      cmd_next    <= cmd_next_s;
      ok_req      <= ok_req_s;
      prog_active <= prog_active_s;
      prog_we     <= prog_we_s;
      prog_done   <= prog_done_s;
      frame_error <= frame_error_s;
      bp_addr     <= bp_addr_s;
      prog_addr   <= prog_addr_s;
      prog_data   <= prog_data_s;
    end
  end

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Scoreboard bench for debug_cmd_decoder: a byte-stream reference model queues
// expected output events, and a negedge monitor pops and compares them.
module tb_debug_cmd_decoder;

  localparam int AW = 2;
  localparam int TO = 64;

  localparam int EV_OK_RISE = 0;
  localparam int EV_OK_FALL = 1;
  localparam int EV_PA_RISE = 2;
  localparam int EV_PA_FALL = 3;
  localparam int EV_PAUSE   = 4;
  localparam int EV_RESUME  = 5;
  localparam int EV_NEXT    = 6;
  localparam int EV_WE      = 7;
  localparam int EV_DONE    = 8;
  localparam int EV_FERR    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          ok_ack;
  logic          cmd_pause, cmd_resume, cmd_next, ok_req, prog_active;
  logic          prog_we, prog_done, frame_error;
  logic [31:0]   bp_addr, prog_data;
  logic [AW-1:0] prog_addr;

  always #5 clk = ~clk;

  debug_cmd_decoder #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_pause(cmd_pause), .cmd_resume(cmd_resume), .bp_addr(bp_addr),
    .cmd_next(cmd_next), .ok_req(ok_req), .ok_ack(ok_ack),
    .prog_active(prog_active), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_done(prog_done), .frame_error(frame_error)
  );

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model: frame-level view of the byte stream
  int          m_st;      // 0 idle, 1 collecting resume argument, 2 collecting program words
  logic [7:0]  m_buf[$];
  int          m_addr;
  int          m_idle;
  bit          m_ok;
  bit          m_pa;
  logic [31:0] m_bp;

  function automatic void push(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_st = 0; m_buf.delete(); m_addr = 0; m_idle = 0;
    m_ok = 1'b0; m_pa = 1'b0; m_bp = 32'd0;
    exp_q.delete();
  endfunction

  function automatic void model_cycle(bit v, logic [7:0] b, bit ack);
    logic [31:0] w;
    bit ping;
    ping = v && (m_st == 0) && (b == 8'h03);
    if (ping && !m_ok) begin
      push(EV_OK_RISE, 32'd0, 32'd0); m_ok = 1'b1;
    end else if (!ping && ack && m_ok) begin
      push(EV_OK_FALL, 32'd0, 32'd0); m_ok = 1'b0;
    end
    if (v) begin
      m_idle = 0;
      if (m_st == 0) begin
        case (b)
          8'h03, 8'hFF: ;
          8'h04: push(EV_PAUSE, 32'd0, 32'd0);
          8'h06: push(EV_NEXT, 32'd0, 32'd0);
          8'h05: begin m_st = 1; m_buf.delete(); end
          8'h07: begin
            m_st = 2; m_buf.delete(); m_addr = 0; m_pa = 1'b1;
            push(EV_PA_RISE, 32'd0, 32'd0);
          end
          default: push(EV_FERR, 32'd0, 32'd0);
        endcase
      end else begin
        m_buf.push_back(b);
        if (m_buf.size() == 4) begin
          w = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          m_buf.delete();
          if (m_st == 1) begin
            m_bp = w; m_st = 0;
            push(EV_RESUME, w, 32'd0);
          end else if (m_addr < (1 << AW)) begin
            push(EV_WE, 32'(m_addr), w);
            m_addr++;
          end else begin
            push(EV_FERR, 32'd0, 32'd0);
          end
        end
      end
    end else if (m_st != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        if (m_st == 1) begin
          push(EV_FERR, 32'd0, 32'd0);
        end else begin
          push(EV_PA_FALL, 32'd0, 32'd0);
          m_pa = 1'b0;
          push(m_buf.size() == 0 ? EV_DONE : EV_FERR, 32'd0, 32'd0);
        end
        m_st = 0; m_buf.delete(); m_idle = 0;
      end
    end
  endfunction

  task automatic check_ev(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL event: got kind=%0d a=%h d=%h, expected nothing", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.d !== d) begin
        miscompares++;
        $display("FAIL event: got kind=%0d a=%h d=%h, expected kind=%0d a=%h d=%h",
                 k, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  // Monitor: every output event seen on the DUT is matched against the queue
  bit prev_ok = 1'b0;
  bit prev_pa = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ok = 1'b0; prev_pa = 1'b0;
    end else begin
      if (ok_req && !prev_ok)      check_ev(EV_OK_RISE, 32'd0, 32'd0);
      if (!ok_req && prev_ok)      check_ev(EV_OK_FALL, 32'd0, 32'd0);
      if (prog_active && !prev_pa) check_ev(EV_PA_RISE, 32'd0, 32'd0);
      if (!prog_active && prev_pa) check_ev(EV_PA_FALL, 32'd0, 32'd0);
      if (cmd_pause)   check_ev(EV_PAUSE, 32'd0, 32'd0);
      if (cmd_resume)  check_ev(EV_RESUME, bp_addr, 32'd0);
      if (cmd_next)    check_ev(EV_NEXT, 32'd0, 32'd0);
      if (prog_we)     check_ev(EV_WE, 32'(prog_addr), prog_data);
      if (prog_done)   check_ev(EV_DONE, 32'd0, 32'd0);
      if (frame_error) check_ev(EV_FERR, 32'd0, 32'd0);
      prev_ok = ok_req; prev_pa = prog_active;
    end
  end

  task automatic tick(bit v, logic [7:0] b, bit ack);
    rx_valid = v; rx_data = v ? b : 8'h00; ok_ack = ack;
    model_cycle(v, b, ack);
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, $urandom_range(0, 7) == 0);
  endtask

  task automatic send(logic [7:0] b);
    tick(1'b1, b, 1'b0);
    idle($urandom_range(1, 4));
  endtask

  task automatic check_state(string name);
    vectors++;
    if ({ok_req, prog_active, bp_addr} !== {m_ok, m_pa, m_bp}) begin
      miscompares++;
      $display("FAIL %s: ok_req=%b prog_active=%b bp_addr=%h, expected %b %b %h",
               name, ok_req, prog_active, bp_addr, m_ok, m_pa, m_bp);
    end
  endtask

  task automatic check_zero(string name);
    vectors++;
    if ({cmd_pause, cmd_resume, cmd_next, ok_req, prog_active, prog_we, prog_done,
         frame_error, bp_addr, prog_addr, prog_data} !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs not all zero (bp_addr=%h prog_addr=%h prog_data=%h ok_req=%b prog_active=%b)",
               name, bp_addr, prog_addr, prog_data, ok_req, prog_active);
    end
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ok_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    check_zero("after_reset_release");

    // Ping handshake, pause, next
    send(8'h03);
    tick(1'b0, 8'h00, 1'b0);
    check_state("ok_req_held");
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check_state("ok_req_cleared");
    send(8'h04);
    send(8'h06);
    // Ping merge, ack+ping in one cycle, stray ack
    send(8'h03);
    send(8'h03);
    tick(1'b1, 8'h03, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check_state("ack_with_ping");
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check_state("stray_ack");

    // Resume, then an aborted resume
    send(8'h05); send(8'h0C); send(8'h00); send(8'h00); send(8'h00);
    send(8'h05); send(8'h04); send(8'h00);
    idle(TO + 8);
    check_state("bp_addr_kept");

    // Two-word program frame ending on timeout
    send(8'h07);
    send(8'h01); send(8'h01); send(8'h01); send(8'h01);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    idle(TO + 8);
    check_state("prog_inactive");

    // Capacity overflow: six words into four slots
    send(8'h07);
    for (int w = 0; w < 6; w++)
      for (int k = 0; k < 4; k++) send(8'(w * 16 + k + 1));
    idle(TO + 8);
    vectors++;
    if (prog_addr !== 2'd3) begin
      miscompares++;
      $display("FAIL prog_addr_saturate: prog_addr=%0d, expected 3", prog_addr);
    end

    // Opcodes as data, partial word abort, invalid byte, NONE
    send(8'h07); send(8'h05); send(8'h07); send(8'h03); send(8'hFF);
    send(8'h06); send(8'h02);
    idle(TO + 8);
    send(8'h42);
    send(8'hFF);
    idle(4);
    check_state("after_misc");

    // Reset in the middle of a resume argument
    tick(1'b1, 8'h05, 1'b0); tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h11, 1'b0); tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_zero("mid_frame_reset");
    rst = 1'b0;
    send(8'h06);
    idle(4);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 7))
        0: send(8'h03);
        1: send(8'h04);
        2: send(8'h06);
        3: begin send(8'h05); for (int k = 0; k < 4; k++) send(8'($urandom)); end
        4: begin
          send(8'h05);
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) send(8'($urandom));
          idle(TO + 8);
        end
        5: begin
          send(8'h07);
          for (int k = 0; k < int'($urandom_range(0, 6)) * 4 + int'($urandom_range(0, 3)); k++)
            send(8'($urandom));
          idle(TO + 8);
        end
        6: send(8'($urandom));
        default: send(8'hFF);
      endcase
    end
    idle(TO + 8);
    check_state("final_state");

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected events never seen, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
